// File: rtl/tube_r3_dma.sv
// tube_r3_dma: parasite-side DMA controller for the Tube register-3 channel.
//
// Moves a programmed block of bytes between Tube R3 and parasite memory. It
// moves one byte for each synchronised drq. Data moves fly-by: the controller
// issues the paired Tube and memory strobes, and the data bus is never routed
// through this block.
//
// Ports:
//   p_phi2     clock
//   p_rst      asynchronous active-high reset
//   cfg_sel/cfg_we/cfg_addr/cfg_wdata   CPU register write port
//   cfg_rdata  combinational register read data (decoded from cfg_addr)
//   drq        Tube R3 DMA request (asynchronous)
//   dack_b     Tube DMA acknowledge, active-low
//   p_rd_b     Tube read strobe, active-low (parasite->host)
//   p_wr_b     Tube write strobe, active-low (host->parasite)
//   bus_req    parasite bus request
//   bus_gnt    parasite bus grant
//   mem_addr   memory address (live address register)
//   mem_rd     memory read strobe
//   mem_wr     memory write strobe
//   dma_irq    terminal-count interrupt (DONE & IEN, registered)
//
// Register map: 0/1 addr lo/hi, 2/3 count lo/hi.
//   4 = ctrl: bit0 START/BUSY, bit1 DIR, bit2 IEN, bit7 DONE (write 1 to clear).
//
// Build option TUBE_DMA_BURST_EN:
//   When it is defined, bus_req is held from the first ARM until terminal
//   count or abort. Once bus_gnt has been seen in the current run, ARM waits
//   only for drq.
module tube_r3_dma #(
  parameter int ADDR_W        = 16,
  parameter int CNT_W         = 16,
  parameter int STROBE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              p_phi2,
  input  logic              p_rst,
  input  logic              cfg_sel,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic [7:0]        cfg_rdata,
  input  logic              drq,
  output logic              dack_b,
  output logic              p_rd_b,
  output logic              p_wr_b,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              dma_irq
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_XFER, S_RECOV, S_HOLD} state_t;

  state_t                 r_state, w_state_next;
  logic [ADDR_W-1:0]      r_addr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_busy, r_dir, r_ien, r_done, r_irq, r_abort_pend;
  logic [7:0]             r_cyc;
  logic [SYNC_STAGES-1:0] r_drq_sync;

  logic        w_drq_s, w_wr, w_wr_ctrl, w_start, w_abort, w_last, w_stop;
  logic        w_done_set, w_gnt_ok, w_hold_req, w_unused_ok;
  logic [15:0] w_addr16, w_count16, w_addr_wr, w_count_wr;

  assign w_drq_s     = r_drq_sync[SYNC_STAGES-1];
  assign w_wr        = cfg_sel & cfg_we;
  assign w_wr_ctrl   = w_wr && (cfg_addr == 3'd4);
  assign w_start     = w_wr_ctrl && cfg_wdata[0] && !r_busy;
  assign w_abort     = w_wr_ctrl && !cfg_wdata[0] && r_busy;
  assign w_last      = (r_count == CNT_W'(1));
  // The byte in flight always finishes. RECOV is where the run is allowed to stop.
  assign w_stop      = w_last | r_abort_pend | w_abort;
  assign w_done_set  = (w_start && (r_count == '0)) ||
                       ((r_state == S_RECOV) && w_last && !r_abort_pend && !w_abort);
  assign w_addr16    = 16'(r_addr);
  assign w_count16   = 16'(r_count);
  assign w_unused_ok = &{1'b0, cfg_wdata[6:3]};
  assign mem_addr    = r_addr;
  assign dma_irq     = r_irq;

`ifdef TUBE_DMA_BURST_EN
  logic r_gnt_seen;
  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst)                        r_gnt_seen <= 1'b0;
    else if (w_state_next == S_IDLE)  r_gnt_seen <= 1'b0;
    else if ((r_state == S_ARM) && bus_gnt) r_gnt_seen <= 1'b1;
  end
  assign w_gnt_ok   = bus_gnt | r_gnt_seen;
  assign w_hold_req = 1'b1;
`else
  assign w_gnt_ok   = bus_gnt;
  assign w_hold_req = 1'b0;
`endif

  // Byte-merge of CPU writes into the live address/count values.
  always_comb begin
    w_addr_wr  = w_addr16;
    w_count_wr = w_count16;
    if (cfg_addr == 3'd0) w_addr_wr[7:0]   = cfg_wdata;
    if (cfg_addr == 3'd1) w_addr_wr[15:8]  = cfg_wdata;
    if (cfg_addr == 3'd2) w_count_wr[7:0]  = cfg_wdata;
    if (cfg_addr == 3'd3) w_count_wr[15:8] = cfg_wdata;
  end

  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      3'd0:    cfg_rdata = w_addr16[7:0];
      3'd1:    cfg_rdata = w_addr16[15:8];
      3'd2:    cfg_rdata = w_count16[7:0];
      3'd3:    cfg_rdata = w_count16[15:8];
      3'd4:    cfg_rdata = {r_done, 4'b0000, r_ien, r_dir, r_busy};
      default: cfg_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // XFER: cycle 0 drops dack_b only. Cycles 1..STROBE_CYCLES assert the strobes.
  // Because of this, dack_b and the strobes never move on the same edge.
  always_comb begin
    w_state_next = r_state;
    dack_b  = 1'b1;
    p_rd_b  = 1'b1;
    p_wr_b  = 1'b1;
    bus_req = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start && (r_count != '0)) w_state_next = S_ARM;
      end
      S_ARM: begin
        bus_req = 1'b1;
        if (w_abort)                   w_state_next = S_IDLE;
        else if (w_drq_s && w_gnt_ok)  w_state_next = S_XFER;
      end
      S_XFER: begin
        bus_req = 1'b1;
        dack_b  = 1'b0;
        if (r_cyc != 8'd0) begin
          if (r_dir) begin
            p_rd_b = 1'b0;
            mem_rd = 1'b1;
          end else begin
            p_wr_b = 1'b0;
            mem_wr = 1'b1;
          end
        end
        if (r_cyc == 8'(STROBE_CYCLES)) w_state_next = S_RECOV;
      end
      S_RECOV: begin
        bus_req = 1'b1;
        dack_b  = 1'b0;
        w_state_next = w_stop ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        // Let the synchroniser flush the drq level from the byte just served.
        bus_req = w_hold_req;
        if (w_abort)                                w_state_next = S_IDLE;
        else if (r_cyc == 8'(SYNC_STAGES - 1))      w_state_next = S_ARM;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) begin
      r_drq_sync   <= '0;
      r_cyc        <= 8'd0;
      r_addr       <= '0;
      r_count      <= '0;
      r_busy       <= 1'b0;
      r_dir        <= 1'b0;
      r_ien        <= 1'b0;
      r_done       <= 1'b0;
      r_irq        <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_drq_sync <= {r_drq_sync[SYNC_STAGES-2:0], drq};
      // The cycle counter restarts on every state change.
      r_cyc      <= (w_state_next != r_state) ? 8'd0 : r_cyc + 8'd1;

      if (r_state == S_RECOV) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count - 1'b1;
      end else if (w_wr && !r_busy) begin
        if (cfg_addr == 3'd0 || cfg_addr == 3'd1) r_addr  <= w_addr_wr[ADDR_W-1:0];
        if (cfg_addr == 3'd2 || cfg_addr == 3'd3) r_count <= w_count_wr[CNT_W-1:0];
      end

      if (w_wr_ctrl) begin
        r_ien <= cfg_wdata[2];
        if (!r_busy) r_dir <= cfg_wdata[1];
      end

      if (w_start && (r_count != '0))
        r_busy <= 1'b1;
      else if (((r_state == S_ARM) || (r_state == S_HOLD)) && w_abort)
        r_busy <= 1'b0;
      else if ((r_state == S_RECOV) && w_stop)
        r_busy <= 1'b0;

      if (r_state == S_RECOV)                 r_abort_pend <= 1'b0;
      else if (w_abort && (r_state == S_XFER)) r_abort_pend <= 1'b1;

      // If DONE is set and cleared on the same edge, the set takes priority.
      if (w_done_set)                      r_done <= 1'b1;
      else if (w_wr_ctrl && cfg_wdata[7])  r_done <= 1'b0;

      r_irq <= r_done & r_ien;
    end
  end

endmodule
